// File: rtl/alarm_clock_pkg.sv
// Shared BCD time types, digit limits and the load-validation helper for the alarm clock.
package alarm_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t ms_hr;
    bcd_digit_t ls_hr;
    bcd_digit_t ms_min;
    bcd_digit_t ls_min;
  } bcd_time_t;

  localparam bcd_digit_t MAX_LS_DIGIT = 4'd9;
  localparam bcd_digit_t MAX_MS_MIN   = 4'd5;
  localparam bcd_digit_t NOKEY        = 4'd10;

  // True when every digit is decimal, minutes are below 60 and hours fit the day length.
  function automatic logic bcd_time_valid(input bcd_time_t t, input int unsigned hours_per_day);
    int unsigned hours;
    hours = ({28'd0, t.ms_hr} * 32'd10) + {28'd0, t.ls_hr};
    return (t.ms_hr  <= MAX_LS_DIGIT) &&
           (t.ls_hr  <= MAX_LS_DIGIT) &&
           (t.ms_min <= MAX_MS_MIN)   &&
           (t.ls_min <= MAX_LS_DIGIT) &&
           (hours < hours_per_day);
  endfunction

endpackage

// File: rtl/bcd_minute_incr.sv
// Combinational next-minute logic for a BCD HH:MM time, wrapping at HOURS_PER_DAY.
module bcd_minute_incr
  import alarm_clock_pkg::*;
#(
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  bcd_time_t cur,
  output bcd_time_t nxt
);

  localparam bcd_digit_t LAST_MS_HR = bcd_digit_t'((HOURS_PER_DAY - 1) / 10);
  localparam bcd_digit_t LAST_LS_HR = bcd_digit_t'((HOURS_PER_DAY - 1) % 10);

  always_comb begin
    nxt = cur;
    if (cur.ls_min != MAX_LS_DIGIT) begin
      nxt.ls_min = cur.ls_min + 4'd1;
    end else begin
      nxt.ls_min = 4'd0;
      if (cur.ms_min != MAX_MS_MIN) begin
        nxt.ms_min = cur.ms_min + 4'd1;
      end else begin
        nxt.ms_min = 4'd0;
        // Last hour of the day rolls to midnight before the ordinary BCD carry.
        if (cur.ms_hr == LAST_MS_HR && cur.ls_hr == LAST_LS_HR) begin
          nxt.ms_hr = 4'd0;
          nxt.ls_hr = 4'd0;
        end else if (cur.ls_hr == MAX_LS_DIGIT) begin
          nxt.ms_hr = cur.ms_hr + 4'd1;
          nxt.ls_hr = 4'd0;
        end else begin
          nxt.ls_hr = cur.ls_hr + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// Current-time and alarm-time registers with minute advance and latched alarm indicator.
module clock_time_keeper
  import alarm_clock_pkg::*;
#(
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        one_minute,
  input  logic        reset_count,
  input  logic        load_new_c,
  input  logic        load_new_a,
  input  logic        alarm_button,
  input  logic [15:0] new_time,
  output logic [15:0] current_time,
  output logic [15:0] alarm_time,
  output logic        sound_alarm
);

  bcd_time_t cur_q;
  bcd_time_t alarm_q;
  bcd_time_t cur_next_min;
  bcd_time_t new_bcd;
  logic      ticked;
  logic      new_ok;
  logic      load_c_ok;
  logic      load_a_ok;
  logic      tick_ok;

  assign new_bcd   = bcd_time_t'(new_time);
  assign new_ok    = bcd_time_valid(new_bcd, HOURS_PER_DAY);
  assign load_c_ok = load_new_c && new_ok;
  assign load_a_ok = load_new_a && new_ok;
  // Any load_new_c strobe, even a rejected one, swallows the tick.
  assign tick_ok   = one_minute && !reset_count && !load_new_c;

  bcd_minute_incr #(
    .HOURS_PER_DAY(HOURS_PER_DAY)
  ) u_incr (
    .cur(cur_q),
    .nxt(cur_next_min)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_q       <= '0;
      alarm_q     <= '0;
      ticked      <= 1'b0;
      sound_alarm <= 1'b0;
    end else begin
      if (load_c_ok) begin
        cur_q <= new_bcd;
      end else if (tick_ok) begin
        cur_q <= cur_next_min;
      end
      if (load_a_ok) begin
        alarm_q <= new_bcd;
      end
      ticked <= tick_ok;
      if (load_a_ok || alarm_button) begin
        sound_alarm <= 1'b0;
      end else if (ticked && (cur_q == alarm_q)) begin
        sound_alarm <= 1'b1;
      end
    end
  end

  assign current_time = cur_q;
  assign alarm_time   = alarm_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed-vector bench for clock_time_keeper with immediate-assertion checks.
module tb_clock_time_keeper;

  logic        clock;
  logic        reset;
  logic        one_minute;
  logic        reset_count;
  logic        load_new_c;
  logic        load_new_a;
  logic        alarm_button;
  logic [15:0] new_time;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        sound_alarm;

  int n_checks;
  int n_fail;

  clock_time_keeper #(.HOURS_PER_DAY(24)) dut (
    .clock(clock),
    .reset(reset),
    .one_minute(one_minute),
    .reset_count(reset_count),
    .load_new_c(load_new_c),
    .load_new_a(load_new_a),
    .alarm_button(alarm_button),
    .new_time(new_time),
    .current_time(current_time),
    .alarm_time(alarm_time),
    .sound_alarm(sound_alarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    one_minute   = 1'b0;
    reset_count  = 1'b0;
    load_new_c   = 1'b0;
    load_new_a   = 1'b0;
    alarm_button = 1'b0;
  endtask

  task automatic load_c(input logic [15:0] t);
    new_time   = t;
    load_new_c = 1'b1;
    step();
    load_new_c = 1'b0;
  endtask

  task automatic load_a(input logic [15:0] t);
    new_time   = t;
    load_new_a = 1'b1;
    step();
    load_new_a = 1'b0;
  endtask

  task automatic tick();
    one_minute = 1'b1;
    step();
    one_minute = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    new_time = 16'h0000;
    reset    = 1'b0;
    repeat (3) step();
    check("reset_cur", current_time, 16'h0000);
    check("reset_alarm", alarm_time, 16'h0000);
    check("reset_sound", {15'd0, sound_alarm}, 16'h0000);
    reset = 1'b1;
    step();

    // 60 back-to-back ticks: 00:00 -> 01:00
    one_minute = 1'b1;
    repeat (30) step();
    check("tick30", current_time, 16'h0030);
    repeat (30) step();
    one_minute = 1'b0;
    check("tick60", current_time, 16'h0100);
    step();
    check("tick60_sound", {15'd0, sound_alarm}, 16'h0000);

    load_a(16'h0715);
    check("load_a_0715", alarm_time, 16'h0715);

    load_c(16'h2359);
    check("load_c_2359", current_time, 16'h2359);
    tick();
    check("wrap_midnight", current_time, 16'h0000);
    load_c(16'h0959);
    tick();
    check("hour_carry", current_time, 16'h1000);
    step();
    check("no_match_sound", {15'd0, sound_alarm}, 16'h0000);

    // Alarm match two cycles after the tick
    load_c(16'h0714);
    tick();
    check("match_cur", current_time, 16'h0715);
    check("match_sound_early", {15'd0, sound_alarm}, 16'h0000);
    step();
    check("match_sound", {15'd0, sound_alarm}, 16'h0001);
    step();
    check("sound_held", {15'd0, sound_alarm}, 16'h0001);
    alarm_button = 1'b1;
    step();
    alarm_button = 1'b0;
    check("button_clear", {15'd0, sound_alarm}, 16'h0000);

    // Invalid loads leave registers alone
    load_c(16'h2460);
    check("invalid_2460", current_time, 16'h0715);
    load_c(16'h1A00);
    check("invalid_1A00", current_time, 16'h0715);
    load_c(16'h2400);
    check("invalid_2400", current_time, 16'h0715);
    load_a(16'h0960);
    check("invalid_alarm", alarm_time, 16'h0715);

    // Simultaneous loads with a tick: load wins, tick is swallowed
    new_time   = 16'h1230;
    load_new_c = 1'b1;
    load_new_a = 1'b1;
    one_minute = 1'b1;
    step();
    idle();
    check("load_beats_tick", current_time, 16'h1230);
    check("dual_load_alarm", alarm_time, 16'h1230);
    step();
    check("load_no_sound", {15'd0, sound_alarm}, 16'h0000);

    // reset_count suppresses a tick
    reset_count = 1'b1;
    tick();
    reset_count = 1'b0;
    check("reset_count_hold", current_time, 16'h1230);

    // Latch, then a new match coinciding with the button: clear wins
    load_c(16'h1229);
    tick();
    step();
    check("relatch", {15'd0, sound_alarm}, 16'h0001);
    load_c(16'h1229);
    tick();
    alarm_button = 1'b1;
    step();
    alarm_button = 1'b0;
    check("clear_beats_set", {15'd0, sound_alarm}, 16'h0000);
    step();
    check("stays_clear", {15'd0, sound_alarm}, 16'h0000);

    // A valid alarm load clears the indicator
    load_c(16'h1229);
    tick();
    step();
    check("latch_again", {15'd0, sound_alarm}, 16'h0001);
    load_a(16'h0800);
    check("load_a_clear", {15'd0, sound_alarm}, 16'h0000);
    check("load_a_0800", alarm_time, 16'h0800);

    // Async reset mid-cycle with the indicator set
    load_c(16'h0759);
    tick();
    step();
    check("pre_reset_sound", {15'd0, sound_alarm}, 16'h0001);
    #2;
    reset = 1'b0;
    #1;
    check("async_cur", current_time, 16'h0000);
    check("async_alarm", alarm_time, 16'h0000);
    check("async_sound", {15'd0, sound_alarm}, 16'h0000);
    step();
    reset = 1'b1;
    step();
    check("post_reset_cur", current_time, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Time-of-day and alarm register stage directly downstream of the alarm-clock control FSM. It consumes the FSM's `load_new_c`, `reset_count` and `load_new_a` strobes together with the four BCD digits assembled from keypad entries. It holds the current time and the alarm time as 24-hour BCD HH:MM and advances the current time on each one-minute tick. It raises and latches `sound_alarm` when a tick brings the current time onto the alarm time.

## Interface
Parameters:
- `HOURS_PER_DAY`, default 24: wrap point of the hour field; the only supported values are 24 and 12.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `one_minute`  in  1  single-cycle tick from the time generator.
- `reset_count`  in  1  from the FSM; restarts the tick prescaler. This block ignores the tick in the same cycle.
- `load_new_c`  in  1  from the FSM; load `new_time` into the current time.
- `load_new_a`  in  1  from the FSM; load `new_time` into the alarm time.
- `alarm_button`  in  1  level input; clears `sound_alarm`.
- `new_time`  in  16  BCD time, {ms_hr, ls_hr, ms_min, ls_min}, 4 bits per digit.
- `current_time`  out  16  current time, BCD, same packing as `new_time`.
- `alarm_time`  out  16  alarm time, BCD, same packing as `new_time`.
- `sound_alarm`  out  1  alarm indicator, latched.

## Operation
- Reset (`reset`=0), asynchronous: `current_time`=16'h0000, `alarm_time`=16'h0000, `sound_alarm`=0, internal `ticked` flag=0.
- Load validation:
  - `new_time` is accepted only if every digit is ≤9, ms_min ≤5, and hours < `HOURS_PER_DAY`.
  - An invalid load is ignored; the target register is unchanged and no error is flagged.
- Current-time register priority, per cycle: valid `load_new_c` > `one_minute` (suppressed when `reset_count`=1 or `load_new_c`=1) > hold.
- Increment rules:
  - ls_min 9→0 carries into ms_min.
  - ms_min 5→0 carries into the hour.
  - Hour x9→(x+1)0.
  - Hour `HOURS_PER_DAY`-1 :59 → 00:00.
- Alarm register: a valid `load_new_a` writes `alarm_time` and clears `sound_alarm` in the same edge. `load_new_a` and `load_new_c` in the same cycle are both honoured.
- `ticked` is set for one cycle by an accepted increment only. Loads never set it, so loading a current time equal to the alarm time does not sound.
- `sound_alarm`:
  - Set on the edge after a cycle where `ticked`=1 and `current_time`==`alarm_time`.
  - Held until cleared, on the edge after `alarm_button`=1, or by a valid `load_new_a`.
  - If a clear and a set occur in the same cycle, the clear wins.
- Reset mid-operation discards any pending tick or match.

## Timing
- `current_time` reflects a load or increment one cycle after the strobe.
- `alarm_time` reflects a load one cycle after `load_new_a`.
- `sound_alarm` rises two cycles after the `one_minute` that produces the match, i.e. one cycle after `current_time` shows the matching value.
- `sound_alarm` falls one cycle after `alarm_button` is sampled high.
- All outputs are registered; there are no combinational input-to-output paths.
- Back-to-back `one_minute` pulses on consecutive cycles each advance the time by one minute.

## Structure
- Package `alarm_clock_pkg` holds:
  - `bcd_digit_t` (logic [3:0]).
  - `bcd_time_t`, a packed struct {ms_hr, ls_hr, ms_min, ls_min}.
  - Constants `MAX_LS_DIGIT`=9, `MAX_MS_MIN`=5, `NOKEY`=4'd10.
  - Function `bcd_time_valid()`.
- One sub-module, `bcd_minute_incr`: combinational next-minute logic, parameterised by `HOURS_PER_DAY`.
- The top level holds the three registers, the `ticked` flag, the comparator and the priority mux.

## Test plan
- Reset, then 60 `one_minute` pulses: `current_time` 00:00 → 01:00; `sound_alarm` stays 0.
- `load_new_c` with 16'h2359, then one tick: `current_time`=16'h0000. Repeat with 16'h0959 → 16'h1000.
- `load_new_a` with 16'h0715, `load_new_c` with 16'h0714, then one tick: `sound_alarm`=1 two cycles after the tick. `alarm_button` pulse: `sound_alarm`=0 next cycle.
- `load_new_c` with 16'h2460, then with 16'h1A00: `current_time` is unchanged in both cases.
- `load_new_c` and `one_minute` in the same cycle with 16'h1230: result is 16'h1230, not 12:31.
- `sound_alarm` latched, then `alarm_button`=1 in the cycle of a new match: `sound_alarm`=0. Async reset asserted mid-cycle: all outputs clear immediately.
